sort4_stream: RTL and testbench

- Sequential 4-entry sorter with valid/ready handshakes on both sides.
- Collects four WIDTH-bit words serially, sorts them in place by odd-even transposition (one compare-exchange phase per clock), then streams them out in ascending order.
- Counterpart to the team's 4-input min/max reducer. It expands a set into an ordered stream instead of reducing it to its extremes.
- Sits between a serial data source and the LED/display or downstream consumer logic.

---
 rtl/sort4_stream.sv | 125 ++++++++++++
 tb/tb_sort4_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort4_stream.sv
// sort4_stream: collects four unsigned words, sorts them in place with four
// odd-even transposition phases (one per clock), then streams them out.
// Build option: define SORT4_DESCEND_EN for descending output order.
module sort4_stream #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [1:0]       load_idx_q, load_idx_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       send_idx_q, send_idx_d;

    // True when the pair (lo, hi) is in the wrong order; ties never swap.
    function automatic logic out_of_order(input logic [WIDTH-1:0] lo,
                                          input logic [WIDTH-1:0] hi);
`ifdef SORT4_DESCEND_EN
        return lo < hi;
`else
        return lo > hi;
`endif
    endfunction

    // State and data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            load_idx_q <= '0;
            phase_q    <= '0;
            send_idx_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            phase_q    <= phase_d;
            send_idx_q <= send_idx_d;
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Next-state logic: load, compare-exchange phases, and send sequencing.
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        phase_d    = phase_q;
        send_idx_d = send_idx_q;
        for (int unsigned i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    data_d[load_idx_q] = in_data;
                    load_idx_d         = load_idx_q + 2'd1;
                    if (load_idx_q == 2'd3) begin
                        load_idx_d = '0;
                        phase_d    = '0;
                        state_d    = SORT;
                    end
                end
            end
            SORT: begin
                if (!phase_q[0]) begin
                    if (out_of_order(data_q[0], data_q[1])) begin
                        data_d[0] = data_q[1];
                        data_d[1] = data_q[0];
                    end
                    if (out_of_order(data_q[2], data_q[3])) begin
                        data_d[2] = data_q[3];
                        data_d[3] = data_q[2];
                    end
                end else begin
                    if (out_of_order(data_q[1], data_q[2])) begin
                        data_d[1] = data_q[2];
                        data_d[2] = data_q[1];
                    end
                end
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d    = SEND;
                    send_idx_d = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    send_idx_d = send_idx_q + 2'd1;
                    if (send_idx_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q != LOAD);
    assign out_data  = (state_q == SEND) ? data_q[send_idx_q] : '0;
    assign out_last  = (state_q == SEND) && (send_idx_q == 2'd3);

endmodule

// File: tb/tb_sort4_stream.sv
// Self-checking bench for sort4_stream using a scoreboard of expected words.
module tb_sort4_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb [$];

    sort4_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference ordering by plain bubble sort; pushes the expected stream.
    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] v [4];
        logic [W-1:0] t;
        logic         sw;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 3; j++) begin
`ifdef SORT4_DESCEND_EN
                sw = v[j] < v[j+1];
`else
                sw = v[j] > v[j+1];
`endif
                if (sw) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        for (int j = 0; j < 4; j++) sb.push_back(v[j]);
    endtask

    // Presents four words; ends on the negedge before the 4th accept edge.
    task automatic send_set(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d,
                            input bit gaps);
        logic [W-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        push_expected(a, b, c, d);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = '1;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v[i];
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready word%0d: got %b want 1", i, in_ready);
            end
        end
    endtask

    // Waits for the sorted stream, checking latency, stalls and the tail.
    task automatic recv_set(input logic [15:0] pat, input string name);
        int lat = 0;
        int k   = 0;
        int n   = 0;
        out_ready = 1'b0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (!out_valid) begin
                total++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s sort_flags: in_ready=%b busy=%b want 0/1", name, in_ready, busy);
                end
            end
        end
        // Negedge 1 follows the accept edge, so 4 clocks of latency shows at 5.
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL %s latency: got %0d want 5", name, lat);
        end
        while (n < 4 && k < 40) begin
            out_ready = (k < 16) ? pat[k] : 1'b1;
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s send_flags: valid=%b busy=%b in_ready=%b want 1/1/0",
                         name, out_valid, busy, in_ready);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s scoreboard_empty: got data %0d want none", name, out_data);
            end else if (out_data !== sb[0] || out_last !== (n == 3)) begin
                bad++;
                $display("FAIL %s word%0d: got data=%0d last=%b want data=%0d last=%b",
                         name, n, out_data, out_last, sb[0], (n == 3));
            end
            if (out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                n++;
            end
            k++;
            if (n < 4) @(negedge clk);
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL %s transfers: got %0d want 4", name, n);
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s after_set: in_ready=%b valid=%b busy=%b last=%b want 1/0/0/0",
                     name, in_ready, out_valid, busy, out_last);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s: in_ready=%b valid=%b busy=%b data=%0d last=%b want 1/0/0/0/0",
                     name, in_ready, out_valid, busy, out_data, out_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check_idle("reset_state");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_release");
    endtask

    task automatic test_basic();
        send_set(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
        recv_set(16'hFFFF, "basic_3120");
    endtask

    task automatic test_gaps_ties();
        send_set(4'd2, 4'd2, 4'd0, 4'd2, 1'b1);
        recv_set(16'hFFFF, "gaps_2202");
    endtask

    task automatic test_backpressure();
        send_set(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        recv_set(16'h0069, "stall_0123");
    endtask

    task automatic test_reset_mid();
        send_set(4'd3, 4'd2, 4'd1, 4'd0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_idle("mid_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        send_set(4'd1, 4'd0, 4'd1, 4'd0, 1'b0);
        recv_set(16'hFFFF, "post_reset_1010");
    endtask

    task automatic test_order_1302();
        send_set(4'd1, 4'd3, 4'd0, 4'd2, 1'b0);
        recv_set(16'hFFFF, "order_1302");
    endtask

    task automatic test_back_to_back();
        send_set(4'd15, 4'd0, 4'd8, 4'd7, 1'b0);
        recv_set(16'hFFFF, "wide_15087");
        send_set(4'd9, 4'd9, 4'd1, 4'd14, 1'b0);
        recv_set(16'hFFFF, "wide_99114");
        send_set(4'd15, 4'd14, 4'd13, 4'd12, 1'b1);
        recv_set(16'h5555, "wide_reverse");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_ties();
        test_backpressure();
        test_reset_mid();
        test_order_1302();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
